// File: rtl/regfile_mp.sv
// regfile_mp: 2W/2R register file with x0 hardwired, write forwarding, busy scoreboard and sequential clear
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int AW = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we0,
  input  logic            we1,
  input  logic [AW-1:0]   wa0,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd0,
  input  logic [XLEN-1:0] wd1,
  input  logic [AW-1:0]   ra0,
  input  logic [AW-1:0]   ra1,
  output logic [XLEN-1:0] rd0,
  output logic [XLEN-1:0] rd1,
  output logic            busy0,
  output logic            busy1,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  input  logic            clr_req,
  output logic            ready
);
  localparam int NREGS = 2 ** AW;
  localparam logic BYP = (BYPASS != 0);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_d;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [AW-1:0] cnt;
  logic w0, w1, rsv;
  logic h00, h01, h10, h11;
  assign ready = (state == IDLE);
  assign w0 = we0 && (wa0 != '0) && ready;
  assign w1 = we1 && (wa1 != '0) && ready;
  assign rsv = rsv_en && (rsv_addr != '0) && ready;
  // hNM: write port N hits read port M this cycle (only when forwarding is enabled)
  assign h00 = BYP && w0 && (wa0 == ra0);
  assign h10 = BYP && w1 && (wa1 == ra0);
  assign h01 = BYP && w0 && (wa0 == ra1);
  assign h11 = BYP && w1 && (wa1 == ra1);
  assign rd0 = h10 ? wd1 : h00 ? wd0 : regs[ra0];
  assign rd1 = h11 ? wd1 : h01 ? wd0 : regs[ra1];
  assign busy0 = busy[ra0] && !(h00 || h10);
  assign busy1 = busy[ra1] && !(h01 || h11);
  always_comb begin
    state_d = state;
    if (state == IDLE) state_d = clr_req ? CLEAR : IDLE;
    else state_d = (cnt == AW'(NREGS - 1)) ? IDLE : CLEAR;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
      cnt <= '0;
      state <= IDLE;
    end else begin
      state <= state_d;
      if (state == CLEAR) begin
        regs[cnt] <= '0;
        busy[cnt] <= 1'b0;
        cnt <= (cnt == AW'(NREGS - 1)) ? '0 : cnt + 1'b1;
      end else begin
        if (clr_req) cnt <= AW'(1);
        if (w0) begin
          regs[wa0] <= wd0;
          busy[wa0] <= 1'b0;
        end
        if (w1) begin
          regs[wa1] <= wd1;
          busy[wa1] <= 1'b0;
        end
        if (rsv) busy[rsv_addr] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp with default parameters
module tb_regfile_mp;
  logic clk = 0, rst = 0;
  logic we0 = 0, we1 = 0, rsv_en = 0, clr_req = 0;
  logic [4:0] wa0 = 0, wa1 = 0, ra0 = 0, ra1 = 0, rsv_addr = 0;
  logic [31:0] wd0 = 0, wd1 = 0, rd0, rd1;
  logic busy0, busy1, ready;
  int checks = 0, passed = 0, n;
  regfile_mp dut (.clk(clk), .rst(rst), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1), .busy0(busy0),
    .busy1(busy1), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req), .ready(ready));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  initial begin
    repeat (2) tick();
    rst = 1;
    ra0 = 5; ra1 = 3;
    #1;
    chk("rst_rd0", rd0, 0); chk("rst_rd1", rd1, 0);
    chk("rst_busy0", {31'b0, busy0}, 0); chk("rst_busy1", {31'b0, busy1}, 0);
    chk("rst_ready", {31'b0, ready}, 1);
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF;
    #1 chk("byp_w0", rd0, 32'hDEADBEEF);
    tick();
    we0 = 0; ra1 = 0;
    #1 chk("stored5", rd0, 32'hDEADBEEF); chk("x0_rd1", rd1, 0);
    we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22; ra0 = 7; ra1 = 5;
    #1 chk("byp_p1_prio", rd0, 32'h22); chk("other_rd1", rd1, 32'hDEADBEEF);
    tick();
    we0 = 0; we1 = 0;
    #1 chk("stored7", rd0, 32'h22);
    rsv_en = 1; rsv_addr = 9; ra0 = 9;
    #1 chk("busy_before_edge", {31'b0, busy0}, 0);
    tick();
    rsv_en = 0;
    #1 chk("busy9_set", {31'b0, busy0}, 1);
    we1 = 1; wa1 = 9; wd1 = 32'h99;
    #1 chk("busy9_fwd_clr", {31'b0, busy0}, 0); chk("byp9", rd0, 32'h99);
    tick();
    we1 = 0;
    #1 chk("busy9_stay0", {31'b0, busy0}, 0); chk("stored9", rd0, 32'h99);
    rsv_en = 1; rsv_addr = 3; we0 = 1; wa0 = 3; wd0 = 32'h33; ra1 = 3;
    tick();
    rsv_en = 0; we0 = 0;
    #1 chk("rsv_wins_busy3", {31'b0, busy1}, 1); chk("stored3", rd1, 32'h33);
    rsv_en = 1; rsv_addr = 0; we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF; ra0 = 0;
    #1 chk("x0_no_byp", rd0, 0); chk("x0_busy_now", {31'b0, busy0}, 0);
    tick();
    rsv_en = 0; we0 = 0;
    #1 chk("x0_rd", rd0, 0); chk("x0_busy", {31'b0, busy0}, 0);
    for (int i = 1; i < 32; i++) begin
      we0 = 1; wa0 = 5'(i); wd0 = 32'h01010101 * i;
      tick();
    end
    we0 = 0; ra1 = 17;
    #1 chk("fill17", rd1, 32'h11111111);
    clr_req = 1; we0 = 1; wa0 = 4; wd0 = 32'h4444; rsv_en = 1; rsv_addr = 12;
    tick();
    we0 = 1; wa0 = 4; wd0 = 32'h5555; rsv_en = 1; rsv_addr = 25; ra0 = 4; ra1 = 1;
    #1 chk("clr_ready0", {31'b0, ready}, 0);
    chk("clr_no_byp", rd0, 32'h4444); chk("clr_reg1_live", rd1, 32'h01010101);
    wa0 = 20; wd0 = 32'hBAD;
    n = 0;
    while (!ready && n < 40) begin
      n++;
      tick();
    end
    we0 = 0; rsv_en = 0; clr_req = 0;
    chk("clr_cycles", n, 31);
    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i);
      #1 chk($sformatf("clr_reg%0d", i), rd0, 0);
      chk($sformatf("clr_busy%0d", i), {31'b0, busy0}, 0);
    end
    chk("clr_ready1", {31'b0, ready}, 1);
    we0 = 1; wa0 = 5; wd0 = 32'h55; we1 = 1; wa1 = 30; wd1 = 32'h30;
    tick();
    we0 = 0; we1 = 0; clr_req = 1;
    tick();
    clr_req = 0;
    repeat (10) tick();
    chk("mid_clr_busy", {31'b0, ready}, 0);
    rst = 0;
    tick();
    rst = 1; ra0 = 30; ra1 = 5;
    #1 chk("abort_ready", {31'b0, ready}, 1);
    chk("abort_reg30", rd0, 0); chk("abort_reg5", rd1, 0);
    we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF; ra0 = 0;
    #1 chk("x0_wr_byp", rd0, 0);
    tick();
    we0 = 0;
    #1 chk("x0_wr_stored", rd0, 0);
    ra0 = 30;
    we0 = 1; wa0 = 30; wd0 = 32'hCAFE;
    tick();
    we0 = 0;
    #1 chk("idle_after_abort", rd0, 32'hCAFE);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter AW, default 5, register address width; register count NREGS = 2**AW.
REQ-003 SHALL have parameter BYPASS, default 1; 1 enables same-cycle write-to-read forwarding, 0 disables it.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports we0/we1  input  1  write enables, ports 0 and 1.
REQ-007 SHALL have ports wa0/wa1  input  AW  write addresses.
REQ-008 SHALL have ports wd0/wd1  input  XLEN  write data.
REQ-009 SHALL have ports ra0/ra1  input  AW  read addresses.
REQ-010 SHALL have ports rd0/rd1  output  XLEN  read data, combinational.
REQ-011 SHALL have ports busy0/busy1  output  1  scoreboard pending-write flag for ra0/ra1.
REQ-012 SHALL have port rsv_en  input  1  reserve request, marks a destination register pending.
REQ-013 SHALL have port rsv_addr  input  AW  register to reserve.
REQ-014 SHALL have port clr_req  input  1  start sequential clear of the register file.
REQ-015 SHALL have port ready  output  1  high when idle and accepting writes/reservations.

Function
REQ-016 Register 0 SHALL always read 0, ignore writes and reservations, and never report busy.
REQ-017 A write with weN=1, waN!=0, ready=1 SHALL update the register at the rising edge.
REQ-018 Both ports writing the same address in one cycle: port 1 data SHALL be stored.
REQ-019 BYPASS=1: rdN SHALL return the same-cycle write data when raN matches an enabled write address (!=0, ready=1), port 1 taking priority; otherwise the stored value.
REQ-020 BYPASS=0: rdN SHALL return only the stored value; new data visible the cycle after the write.
REQ-021 Scoreboard: one busy bit per register; rsv_en=1, rsv_addr!=0, ready=1 SHALL set busy[rsv_addr] at the edge.
REQ-022 An enabled write on either port SHALL clear busy[waN] at the edge.
REQ-023 Reserve and write to the same address in the same cycle: busy SHALL end set (new producer wins).
REQ-024 busyN SHALL equal busy[raN], forced 0 when BYPASS=1 and an enabled same-cycle write targets raN.
REQ-025 FSM states: IDLE, CLEAR; ready=1 in IDLE, 0 in CLEAR.
REQ-026 IDLE->CLEAR on clr_req=1; clear counter loads 1.
REQ-027 In CLEAR, each cycle SHALL zero register[cnt] and busy[cnt], then increment cnt.
REQ-028 CLEAR->IDLE in the cycle register NREGS-1 is zeroed; total CLEAR duration NREGS-1 cycles.
REQ-029 In CLEAR, writes, reservations and clr_req SHALL be ignored; reads return current stored contents (partially cleared), no bypass.
REQ-030 Simultaneous clr_req with a write/reserve in IDLE: the write/reserve SHALL take effect, then clearing begins next cycle.
REQ-031 Clear counter SHALL be AW bits wide; no wrap beyond NREGS-1.

Reset
REQ-032 rst=0 at a rising edge SHALL zero all registers and busy bits, set state IDLE, counter 0.
REQ-033 After reset: rd0/rd1=0, busy0/busy1=0, ready=1.
REQ-034 Reset SHALL override all other inputs, including abort of an in-progress CLEAR.

Verification
REQ-035 Reset, then we0=1 wa0=5 wd0=0xDEADBEEF; next cycle ra0=5 -> rd0=0xDEADBEEF; ra1=0 -> rd1=0.
REQ-036 Same cycle we0 wa0=7 wd0=0x11, we1 wa1=7 wd1=0x22, ra0=7 -> BYPASS=1: rd0=0x22 that cycle; stored 0x22 next.
REQ-037 rsv_en rsv_addr=9 -> busy0=1 for ra0=9 next cycle; write wa1=9 -> busy0=0 same cycle (BYPASS=1) and stays 0.
REQ-038 Same cycle rsv_en rsv_addr=3 and we0 wa0=3 -> register 3 updated, busy[3]=1 afterwards.
REQ-039 Fill regs 1..31 with nonzero, pulse clr_req -> ready=0 for 31 cycles, writes ignored, then ready=1, all regs 0, all busy 0.
REQ-040 rst=0 midway through CLEAR -> next cycle ready=1, all regs 0, state IDLE; write to x0 with wd0=0xFFFFFFFF -> rd0=0 for ra0=0.
